// File: rtl/drlp_pe_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : drlp_pe_pkg
//  Description : Shared geometry and feeder FSM encoding for the PE datapath
//                and the window feeder that drives it.
//  Revision    : 1.0  initial release
// ============================================================================
package drlp_pe_pkg;

   localparam int DATA_WIDTH        = 8;
   localparam int ROW_NUM           = 6;
   localparam int COLUMN_NUM        = 6;
   localparam int COLUMN_DATA_WIDTH = DATA_WIDTH * ROW_NUM;
   localparam int TOTAL_IN_WIDTH    = COLUMN_DATA_WIDTH * COLUMN_NUM;
   localparam int IMG_WIDTH_BITS    = 8;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_FILL = 2'd1,
      ST_RUN  = 2'd2,
      ST_DONE = 2'd3
   } feeder_state_t;

endpackage
`default_nettype wire

// File: rtl/img_col_shifter.sv
`default_nettype none
// ============================================================================
//  Module      : img_col_shifter
//  Description : Column shift register holding the sliding window. Slot 0
//                (LSBs) is the oldest column; new columns enter the top slot.
//  Revision    : 1.0  initial release
// ============================================================================
module img_col_shifter #(
   parameter int COLUMN_DATA_WIDTH = 48,
   parameter int COLUMN_NUM        = 6,
   parameter int TOTAL_IN_WIDTH    = COLUMN_DATA_WIDTH * COLUMN_NUM
) (
   input  logic                         clk,
   input  logic                         clear,
   input  logic                         shift_en,
   input  logic [COLUMN_DATA_WIDTH-1:0] col_in,
   output logic [TOTAL_IN_WIDTH-1:0]    window
);

   logic [TOTAL_IN_WIDTH-1:0] r_window;

   // Shift every slot down one place and load the new column on top.
   always_ff @(posedge clk) begin
      if (clear) begin
         r_window <= '0;
      end else if (shift_en) begin
         r_window <= {col_in, r_window[TOTAL_IN_WIDTH-1:COLUMN_DATA_WIDTH]};
      end
   end

   assign window = r_window;

endmodule
`default_nettype wire

// File: rtl/img_window_feeder.sv
`default_nettype none
// ============================================================================
//  Module      : img_window_feeder
//  Description : Streams image columns into a COLUMN_NUM-wide sliding window
//                and hands complete windows to the PE with valid/ready.
//  Revision    : 1.0  initial release
// ============================================================================
module img_window_feeder #(
   parameter int DATA_WIDTH        = 8,
   parameter int COLUMN_NUM        = 6,
   parameter int ROW_NUM           = 6,
   parameter int COLUMN_DATA_WIDTH = DATA_WIDTH * ROW_NUM,
   parameter int TOTAL_IN_WIDTH    = COLUMN_DATA_WIDTH * COLUMN_NUM
) (
   input  logic                         i_clk,
   input  logic                         i_rst,
   input  logic                         i_start,
   input  logic [7:0]                   i_img_width,
   input  logic                         i_col_valid,
   input  logic [COLUMN_DATA_WIDTH-1:0] i_col_data,
   output logic                         o_col_ready,
   output logic [TOTAL_IN_WIDTH-1:0]    o_img,
   output logic                         o_img_valid,
   input  logic                         i_img_ready,
   output logic                         o_busy,
   output logic                         o_strip_done
);

   import drlp_pe_pkg::*;

   localparam logic [7:0] C_MIN_WIDTH = 8'(COLUMN_NUM);
   localparam logic [7:0] C_LAST_FILL = 8'(COLUMN_NUM - 1);

   feeder_state_t r_state;
   feeder_state_t w_state_nxt;
   logic [7:0]    r_col_cnt;
   logic [7:0]    r_width;
   logic          r_img_valid;
   logic          w_start_ok;
   logic          w_at_end;
   logic          w_col_ready;
   logic          w_accept;
   logic          w_consume;
   logic          w_busy;
   logic          w_strip_done;

   assign w_start_ok = i_start && (i_img_width >= C_MIN_WIDTH);
   assign w_at_end   = (r_col_cnt == r_width);
   assign w_accept   = i_col_valid && w_col_ready;
   assign w_consume  = r_img_valid && i_img_ready;

   // State register.
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_state <= ST_IDLE;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   // Next-state and handshake decode; ready drops once the strip is fully read.
   always_comb begin
      w_state_nxt  = r_state;
      w_col_ready  = 1'b0;
      w_busy       = 1'b1;
      w_strip_done = 1'b0;
      case (r_state)
         ST_IDLE: begin
            w_busy = 1'b0;
            if (w_start_ok) begin
               w_state_nxt = ST_FILL;
            end
         end
         ST_FILL: begin
            w_col_ready = !w_at_end;
            if (w_accept && (r_col_cnt == C_LAST_FILL)) begin
               w_state_nxt = ST_RUN;
            end
         end
         ST_RUN: begin
            w_col_ready = !w_at_end && (!r_img_valid || i_img_ready);
            if (w_consume && w_at_end) begin
               w_state_nxt = ST_DONE;
            end
         end
         ST_DONE: begin
            w_strip_done = 1'b1;
            w_state_nxt  = ST_IDLE;
         end
         default: begin
            w_state_nxt = ST_IDLE;
         end
      endcase
   end

   // Width latch, column counter and window-valid flag.
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_width     <= '0;
         r_col_cnt   <= '0;
         r_img_valid <= 1'b0;
      end else begin
         if ((r_state == ST_IDLE) && w_start_ok) begin
            r_width   <= i_img_width;
            r_col_cnt <= '0;
         end else if (w_accept) begin
            r_col_cnt <= r_col_cnt + 8'd1;
         end
         // Any accept from the last fill column on completes a fresh window.
         if (w_accept && (r_col_cnt >= C_LAST_FILL)) begin
            r_img_valid <= 1'b1;
         end else if (w_consume) begin
            r_img_valid <= 1'b0;
         end
      end
   end

   img_col_shifter #(
      .COLUMN_DATA_WIDTH (COLUMN_DATA_WIDTH),
      .COLUMN_NUM        (COLUMN_NUM),
      .TOTAL_IN_WIDTH    (TOTAL_IN_WIDTH)
   ) u_col_shifter (
      .clk      (i_clk),
      .clear    (i_rst),
      .shift_en (w_accept),
      .col_in   (i_col_data),
      .window   (o_img)
   );

   assign o_col_ready  = w_col_ready;
   assign o_img_valid  = r_img_valid;
   assign o_busy       = w_busy;
   assign o_strip_done = w_strip_done;

endmodule
`default_nettype wire

// File: tb/tb_img_window_feeder.sv
`default_nettype none
// ============================================================================
//  Module      : tb_img_window_feeder
//  Description : Directed self-checking bench for img_window_feeder.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_img_window_feeder;

   logic         clk;
   logic         rst;
   logic         i_start;
   logic [7:0]   i_img_width;
   logic         i_col_valid;
   logic [47:0]  i_col_data;
   logic         o_col_ready;
   logic [287:0] o_img;
   logic         o_img_valid;
   logic         i_img_ready;
   logic         o_busy;
   logic         o_strip_done;

   int n_checks = 0;
   int n_errors = 0;

   img_window_feeder u_dut (
      .i_clk        (clk),
      .i_rst        (rst),
      .i_start      (i_start),
      .i_img_width  (i_img_width),
      .i_col_valid  (i_col_valid),
      .i_col_data   (i_col_data),
      .o_col_ready  (o_col_ready),
      .o_img        (o_img),
      .o_img_valid  (o_img_valid),
      .i_img_ready  (i_img_ready),
      .o_busy       (o_busy),
      .o_strip_done (o_strip_done)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [287:0] act, input logic [287:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h", tag, act, exp);
      end
   endtask

   // Window w holds columns w..w+5; every pixel of column i equals i.
   function automatic logic [287:0] exp_win(input int w);
      logic [287:0] v;
      v = '0;
      for (int k = 0; k < 6; k++) v[k*48 +: 48] = {6{8'(w + k)}};
      return v;
   endfunction

   task automatic run_strip(input int width, input int bp_win, input int bp_len,
                            input int starve_at, input int starve_len,
                            input int busy_start_at, output int span);
      int col_idx = 0, win_idx = 0, bp_cnt = 0, st_cnt = 0, cyc = 0;
      int first_cons = -1, last_cons = -10, done_cyc = -1;
      bit prev_full = 0, starving, stall, acc, cons;
      @(negedge clk);
      i_start = 1'b1; i_img_width = 8'(width); i_col_valid = 1'b0; i_img_ready = 1'b0;
      @(negedge clk);
      i_start = 1'b0;
      check("busy_after_start", o_busy, 1);
      while (done_cyc < 0 && cyc < 200) begin
         i_start     = (cyc == busy_start_at);
         i_img_width = (cyc == busy_start_at) ? 8'd20 : 8'(width);
         starving    = (col_idx == starve_at) && (st_cnt < starve_len);
         i_col_valid = (col_idx < width) && !starving;
         i_col_data  = {6{8'(col_idx)}};
         stall       = o_img_valid && (win_idx == bp_win) && (bp_cnt < bp_len);
         i_img_ready = !stall;
         #1;
         if (prev_full) check("valid_after_accept", o_img_valid, 1);
         if (stall) begin
            check("stall_img_stable", o_img, exp_win(win_idx));
            check("stall_col_ready", o_col_ready, 0);
            bp_cnt++;
         end
         if (starving) begin
            if (st_cnt >= 1) check("starve_valid_low", o_img_valid, 0);
            st_cnt++;
         end
         if (o_strip_done) begin
            done_cyc = cyc;
            check("done_gap", cyc - last_cons, 1);
         end
         acc  = i_col_valid && o_col_ready;
         cons = o_img_valid && i_img_ready;
         if (cons) begin
            check("window", o_img, exp_win(win_idx));
            if (first_cons < 0) first_cons = cyc;
            last_cons = cyc;
            win_idx++;
         end
         prev_full = acc && (col_idx >= 5);
         if (acc) col_idx++;
         @(negedge clk);
         cyc++;
      end
      if (done_cyc < 0) check("timeout", 0, 1);
      check("window_count", win_idx, width - 5);
      check("cols_accepted", col_idx, width);
      i_start = 1'b0; i_col_valid = 1'b0; i_img_ready = 1'b0;
      #1;
      check("idle_after_done", o_busy, 0);
      span = last_cons - first_cons;
   endtask

   initial begin
      int span;
      rst = 1'b1; i_start = 1'b0; i_img_width = 8'd0; i_col_valid = 1'b0;
      i_col_data = '0; i_img_ready = 1'b0;
      repeat (2) @(negedge clk);
      check("rst_img", o_img, 0);
      check("rst_valid", o_img_valid, 0);
      check("rst_col_ready", o_col_ready, 0);
      check("rst_busy", o_busy, 0);
      check("rst_done", o_strip_done, 0);
      rst = 1'b0;

      // Normal strip: 3 back-to-back windows.
      run_strip(8, -1, 0, -1, 0, -1, span);
      check("normal_span", span, 2);

      // Back-pressure on window 1.
      run_strip(8, 1, 4, -1, 0, -1, span);

      // Source starvation in RUN.
      run_strip(8, -1, 0, 7, 3, -1, span);

      // Minimum width.
      run_strip(6, -1, 0, -1, 0, -1, span);

      // Illegal width is ignored.
      @(negedge clk);
      i_start = 1'b1; i_img_width = 8'd5; i_col_valid = 1'b1;
      @(negedge clk);
      i_start = 1'b0;
      check("w5_busy", o_busy, 0);
      check("w5_col_ready", o_col_ready, 0);
      @(negedge clk);
      check("w5_busy_later", o_busy, 0);
      i_col_valid = 1'b0;

      // Reset in the middle of a width-10 strip.
      i_start = 1'b1; i_img_width = 8'd10;
      @(negedge clk);
      i_start = 1'b0; i_col_valid = 1'b1; i_img_ready = 1'b1;
      for (int c = 0; c < 4; c++) begin
         i_col_data = {6{8'(c)}};
         #1;
         check("mid_fill_ready", o_col_ready, 1);
         @(negedge clk);
      end
      rst = 1'b1; i_start = 1'b1; i_col_data = {6{8'd4}};
      @(negedge clk);
      check("mrst_img", o_img, 0);
      check("mrst_valid", o_img_valid, 0);
      check("mrst_col_ready", o_col_ready, 0);
      check("mrst_busy", o_busy, 0);
      check("mrst_done", o_strip_done, 0);
      rst = 1'b0; i_start = 1'b0; i_col_valid = 1'b0; i_img_ready = 1'b0;
      @(negedge clk);
      check("mrst_still_idle", o_busy, 0);
      run_strip(7, -1, 0, -1, 0, -1, span);

      // Start pulse while busy is ignored.
      run_strip(8, -1, 0, -1, 0, 3, span);

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule
`default_nettype wire
